// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing and state encoding for the RAM-backed FIFO controller.
// Widths here are the defaults picked up by the interface and the top.
package ram_fifo_ctrl_pkg;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int DEPTH = 1 << N;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Request/response and dual-port RAM signals of the FIFO controller.
// The slave modport is the controller's view; the master modport is its environment.
interface ram_fifo_ctrl_if #(
    parameter int N = ram_fifo_ctrl_pkg::N,
    parameter int M = ram_fifo_ctrl_pkg::M
);

    logic         push;
    logic [M-1:0] push_data;
    logic         pop;
    logic [M-1:0] pop_data;
    logic         pop_valid;
    logic         full;
    logic         empty;
    logic [N:0]   count;
    logic         busy;
    logic         ram_r;
    logic         ram_w;
    logic [N-1:0] ram_address_in;
    logic [N-1:0] ram_address_out;
    logic [M-1:0] ram_d_in;
    logic [M-1:0] ram_d_out;

    modport slave (
        input  push, push_data, pop, ram_d_out,
        output pop_data, pop_valid, full, empty, count, busy,
               ram_r, ram_w, ram_address_in, ram_address_out, ram_d_in
    );

    modport master (
        output push, push_data, pop, ram_d_out,
        input  pop_data, pop_valid, full, empty, count, busy,
               ram_r, ram_w, ram_address_in, ram_address_out, ram_d_in
    );

endinterface

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// Wrapping W-bit pointer with synchronous clear and count enable.
// Reset and clear both force zero; clear has priority over enable.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk_t,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] PTR_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (en) begin
            ptr_d = ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_t) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external dual-port RAM: zero-fills the RAM after reset,
// then queues pushes and issues reads whose data returns two cycles after the pop.
module ram_fifo_ctrl #(
    parameter int N = ram_fifo_ctrl_pkg::N,
    parameter int M = ram_fifo_ctrl_pkg::M
) (
    input  logic           clk_t,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);

    import ram_fifo_ctrl_pkg::*;

    localparam logic [N:0] CNT_ONE = {{N{1'b0}}, 1'b1};
    localparam logic [N:0] CNT_MAX = {1'b1, {N{1'b0}}};

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         ram_w_q, ram_w_d;
    logic         ram_r_q, ram_r_d;
    logic [N-1:0] ram_addr_in_q, ram_addr_in_d;
    logic [N-1:0] ram_addr_out_q, ram_addr_out_d;
    logic [M-1:0] ram_d_in_q, ram_d_in_d;
    logic [M-1:0] pop_data_q, pop_data_d;
    logic         pop_valid_q, pop_valid_d;
    logic [N:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;

    logic [N-1:0] wr_ptr;
    logic [N-1:0] rd_ptr;
    logic [N-1:0] init_ptr;
    logic         push_acc;
    logic         pop_acc;
    logic         in_init;

    assign in_init  = (state_q == ST_INIT);
    // Full/empty are the registered flags, so a push+pop pair on a full FIFO
    // only accepts the pop and on an empty FIFO only accepts the push.
    assign push_acc = (state_q == ST_RUN) && bus.push && !full_q;
    assign pop_acc  = (state_q == ST_RUN) && bus.pop && !empty_q;

    fifo_ptr #(.W(N)) u_wr_ptr (
        .clk_t (clk_t),
        .rst   (rst),
        .clr   (in_init),
        .en    (push_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(N)) u_rd_ptr (
        .clk_t (clk_t),
        .rst   (rst),
        .clr   (in_init),
        .en    (pop_acc),
        .ptr   (rd_ptr)
    );

    fifo_ptr #(.W(N)) u_init_ptr (
        .clk_t (clk_t),
        .rst   (rst),
        .clr   (!in_init),
        .en    (in_init),
        .ptr   (init_ptr)
    );

    always_comb begin
        state_d        = state_q;
        // busy lags the state by one cycle so it covers the final init write
        busy_d         = in_init;
        ram_w_d        = 1'b0;
        ram_r_d        = 1'b0;
        ram_addr_in_d  = ram_addr_in_q;
        ram_addr_out_d = ram_addr_out_q;
        ram_d_in_d     = ram_d_in_q;
        pop_valid_d    = ram_r_q;
        pop_data_d     = pop_data_q;
        count_d        = count_q;

        if (ram_r_q) begin
            pop_data_d = bus.ram_d_out;
        end

        case (state_q)
            ST_INIT: begin
                ram_w_d       = 1'b1;
                ram_addr_in_d = init_ptr;
                ram_d_in_d    = '0;
                if (init_ptr == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (push_acc) begin
                    ram_w_d       = 1'b1;
                    ram_addr_in_d = wr_ptr;
                    ram_d_in_d    = bus.push_data;
                end
                if (pop_acc) begin
                    ram_r_d        = 1'b1;
                    ram_addr_out_d = rd_ptr;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_t) begin
        if (rst) begin
            state_q        <= ST_INIT;
            busy_q         <= 1'b1;
            ram_w_q        <= 1'b0;
            ram_r_q        <= 1'b0;
            ram_addr_in_q  <= '0;
            ram_addr_out_q <= '0;
            ram_d_in_q     <= '0;
            pop_data_q     <= '0;
            pop_valid_q    <= 1'b0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            ram_w_q        <= ram_w_d;
            ram_r_q        <= ram_r_d;
            ram_addr_in_q  <= ram_addr_in_d;
            ram_addr_out_q <= ram_addr_out_d;
            ram_d_in_q     <= ram_d_in_d;
            pop_data_q     <= pop_data_d;
            pop_valid_q    <= pop_valid_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.ram_w           = ram_w_q;
    assign bus.ram_r           = ram_r_q;
    assign bus.ram_address_in  = ram_addr_in_q;
    assign bus.ram_address_out = ram_addr_out_q;
    assign bus.ram_d_in        = ram_d_in_q;
    assign bus.pop_data        = pop_data_q;
    assign bus.pop_valid       = pop_valid_q;
    assign bus.count           = count_q;
    assign bus.full            = full_q;
    assign bus.empty           = empty_q;

endmodule
